crc8_frame_arbiter: RTL and testbench

Shares one CRC-8 checksum engine between two byte-stream requesters. Whole frames are granted round-robin. Granted data bytes pass through to a single output stream, and the engine accumulates the checksum over them. After each frame the block appends one check byte and tags every output beat with the source id. It sits between the packet sources and the serial link framer.

---
 rtl/crc8_pkg.sv | 26 ++
 rtl/crc8_engine.sv | 39 +++
 rtl/crc8_frame_arbiter.sv | 170 +++++++++++++++++
 tb/tb_crc8_frame_arbiter.sv | 521 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc8_pkg.sv
// Shared types, constants and the bytewise CRC-8 step for the frame arbiter.
// Used by crc8_engine and crc8_frame_arbiter.
package crc8_pkg;

   localparam int         NUM_REQ           = 2;
   localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2
   } state_t;

   // MSB-first: fold the byte in, then eight shift/conditional-XOR rounds.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                            input logic [7:0] data_byte,
                                            input logic [7:0] poly);
      logic [7:0] c;
      c = crc ^ data_byte;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ poly) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc8_engine.sv
// CRC-8 accumulator: init_i reloads INIT, update_i folds byte_i into the register.
// init_i wins if both strobes are high in the same cycle.
module crc8_engine
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       init_i,
   input  logic       update_i,
   input  logic [7:0] byte_i,
   output logic [7:0] crc_o
);

   logic [7:0] crc_q;
   logic [7:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (init_i) begin
         crc_d = INIT;
      end else if (update_i) begin
         crc_d = crc8_step(crc_q, byte_i, POLY);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q <= INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/crc8_frame_arbiter.sv
// Round-robin frame arbiter feeding a shared CRC-8 engine; appends a check byte per frame.
// Define CRC_STATS_EN to add per-requester frame counters, a sticky stall flag and stats_clr.
module crc8_frame_arbiter
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY   = CRC8_POLY_DEFAULT,
   parameter logic [7:0] INIT   = 8'h00,
   parameter logic [7:0] XOROUT = 8'h00
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     in_valid,
   input  logic [8*NUM_REQ-1:0]   in_data,
   input  logic [NUM_REQ-1:0]     in_last,
   output logic [NUM_REQ-1:0]     in_ready,
   output logic                   out_valid,
   output logic [7:0]             out_data,
   output logic                   out_last,
   output logic                   out_src,
   input  logic                   out_ready,
`ifdef CRC_STATS_EN
   output logic [16*NUM_REQ-1:0]  frame_cnt,
   output logic                   stall_flag,
   input  logic                   stats_clr,
`endif
   output logic                   busy
);

   state_t     state_q;
   state_t     state_d;
   logic       grant_q;
   logic       grant_d;
   logic       rr_ptr_q;
   logic       rr_ptr_d;

   logic [7:0] req_byte [NUM_REQ];
   logic [7:0] g_byte;
   logic       g_valid;
   logic       g_last;
   logic       data_hs;
   logic       crc_hs;
   logic       crc_init;
   logic [7:0] crc_val;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign req_byte[gi] = in_data[8*gi +: 8];
         // Only the granted requester may ever see ready.
         assign in_ready[gi] = (state_q == DATA) && (grant_q == 1'(gi)) && out_ready;
      end
   endgenerate

   assign g_byte   = req_byte[grant_q];
   assign g_valid  = in_valid[grant_q];
   assign g_last   = in_last[grant_q];
   assign data_hs  = (state_q == DATA) && g_valid && out_ready;
   assign crc_hs   = (state_q == CRC) && out_ready;
   assign crc_init = (state_q == IDLE) && (|in_valid);

   crc8_engine #(
      .POLY (POLY),
      .INIT (INIT)
   ) u_engine (
      .clk      (clk),
      .rst      (rst),
      .init_i   (crc_init),
      .update_i (data_hs),
      .byte_i   (g_byte),
      .crc_o    (crc_val)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= 1'b0;
         rr_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (|in_valid) begin
               // rr_ptr_q names the requester favoured for the next grant.
               grant_d = in_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
               state_d = DATA;
            end
         end
         DATA: begin
            if (data_hs && g_last) begin
               state_d = CRC;
            end
         end
         CRC: begin
            if (crc_hs) begin
               rr_ptr_d = ~grant_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      out_src   = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE: begin
         end
         DATA: begin
            out_valid = g_valid;
            out_data  = g_byte;
            out_src   = grant_q;
            busy      = 1'b1;
         end
         CRC: begin
            out_valid = 1'b1;
            out_data  = crc_val ^ XOROUT;
            out_last  = 1'b1;
            out_src   = grant_q;
            busy      = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef CRC_STATS_EN
   logic [15:0] frame_cnt_q [NUM_REQ];
   logic        stall_flag_q;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               frame_cnt_q[gi] <= 16'h0000;
            end else if (stats_clr) begin
               frame_cnt_q[gi] <= 16'h0000;
            end else if (crc_hs && (grant_q == 1'(gi))) begin
               frame_cnt_q[gi] <= frame_cnt_q[gi] + 16'd1;
            end
         end
         assign frame_cnt[16*gi +: 16] = frame_cnt_q[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_flag_q <= 1'b0;
      end else if (stats_clr) begin
         stall_flag_q <= 1'b0;
      end else if ((state_q == CRC) && !out_ready) begin
         stall_flag_q <= 1'b1;
      end
   end

   assign stall_flag = stall_flag_q;
`endif

endmodule

// File: tb/tb_crc8_frame_arbiter.sv
// Self-checking bench for crc8_frame_arbiter: directed scenarios plus randomized
// two-requester traffic checked against a frame-level reference model.
module tb_crc8_frame_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  in_valid;
   logic [15:0] in_data;
   logic [1:0]  in_last;
   logic [1:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_src;
   logic        out_ready = 1'b1;
   logic        busy;
`ifdef CRC_STATS_EN
   logic [31:0] frame_cnt;
   logic        stall_flag;
   logic        stats_clr = 1'b0;
`endif

   logic        drv_valid [2];
   logic        drv_last  [2];
   logic [7:0]  drv_data  [2];

   int n_vec = 0;
   int n_err = 0;

   localparam int NF = 6;
   logic [7:0] rnd_bytes [2][$];
   int         rnd_len   [2][$];
   logic       mon_done;

   always #5 clk = ~clk;

   assign in_valid = {drv_valid[1], drv_valid[0]};
   assign in_last  = {drv_last[1], drv_last[0]};
   assign in_data  = {drv_data[1], drv_data[0]};

   crc8_frame_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready),
`ifdef CRC_STATS_EN
      .frame_cnt (frame_cnt),
      .stall_flag(stall_flag),
      .stats_clr (stats_clr),
`endif
      .busy      (busy)
   );

   // Bit-serial polynomial division, MSB first, INIT=0, XOROUT=0.
   function automatic logic [7:0] ref_crc(input logic [7:0] bytes[$]);
      logic [7:0] c;
      logic       fb;
      c = 8'h00;
      foreach (bytes[i]) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[7] ^ bytes[i][b];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
         end
      end
      return c;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      for (int r = 0; r < 2; r++) begin
         drv_valid[r] = 1'b0;
         drv_last[r]  = 1'b0;
         drv_data[r]  = 8'h00;
      end
   endtask

   task automatic apply_reset;
      idle_inputs();
      out_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // Sends one frame from requester r alone (DUT must be idle) and checks every output beat.
   task automatic run_frame(input int r, input logic [7:0] q[$], input string tag);
      logic [1:0]  exp_rdy;
      logic [10:0] exp_beat;
      exp_rdy = (r == 1) ? 2'b10 : 2'b01;
      drv_valid[r] = 1'b1;
      drv_data[r]  = q[0];
      drv_last[r]  = (q.size() == 1);
      #1;
      n_vec++;
      if ({busy, out_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL %s_idle: busy/out_valid=%b required 00", tag, {busy, out_valid});
      end
      tick();
      for (int i = 0; i < q.size(); i++) begin
         drv_data[r] = q[i];
         drv_last[r] = (i == q.size() - 1);
         #1;
         exp_beat = {1'b1, 1'b0, 1'(r), q[i]};
         n_vec++;
         if ({out_valid, out_last, out_src, out_data} !== exp_beat || in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL %s_data[%0d]: v/l/s/d=%b rdy=%b required %b rdy=%b", tag, i,
                     {out_valid, out_last, out_src, out_data}, in_ready, exp_beat, exp_rdy);
         end
         tick();
      end
      drv_valid[r] = 1'b0;
      drv_last[r]  = 1'b0;
      #1;
      exp_beat = {1'b1, 1'b1, 1'(r), ref_crc(q)};
      n_vec++;
      if ({out_valid, out_last, out_src, out_data} !== exp_beat || in_ready !== 2'b00) begin
         n_err++;
         $display("FAIL %s_crc: v/l/s/d=%b rdy=%b required %b rdy=00", tag,
                  {out_valid, out_last, out_src, out_data}, in_ready, exp_beat);
      end
      tick();
   endtask

   task automatic test_reset;
      drv_valid[0] = 1'b1; drv_data[0] = 8'hA5; drv_last[0] = 1'b0;
      drv_valid[1] = 1'b1; drv_data[1] = 8'h5A; drv_last[1] = 1'b1;
      out_ready = 1'b1;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_vec++;
         if ({out_valid, out_last, out_src, busy, in_ready} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs[%0d]: v/l/s/busy/rdy=%b required 000000", k,
                     {out_valid, out_last, out_src, busy, in_ready});
         end
         tick();
      end
`ifdef CRC_STATS_EN
      n_vec++;
      if ({frame_cnt, stall_flag} !== 33'b0) begin
         n_err++;
         $display("FAIL reset_stats: cnt=%h flag=%b required 0", frame_cnt, stall_flag);
      end
`endif
      idle_inputs();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_byte;
      logic [7:0] q[$];
      q = {8'h01};
      run_frame(0, q, "single_byte");
   endtask

   task automatic test_check_vector;
      logic [7:0] q[$];
      q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      run_frame(1, q, "check_vector");
   endtask

   task automatic test_round_robin;
      logic [7:0] qa[$];
      logic [7:0] qb[$];
      logic [7:0] qc[$];
      logic [11:0] exp_v;
      qa = {8'hFF};
      qb = {8'h5A};
      qc = {8'h3C};
      apply_reset();
      drv_valid[0] = 1'b1; drv_data[0] = 8'hFF; drv_last[0] = 1'b1;
      drv_valid[1] = 1'b1; drv_data[1] = 8'h5A; drv_last[1] = 1'b1;
      tick();
      exp_v = {1'b1, 1'b0, 1'b0, 8'hFF, 1'b1};
      n_vec++;
      if ({out_valid, out_last, out_src, out_data, in_ready[0]} !== exp_v || in_ready[1] !== 1'b0) begin
         n_err++;
         $display("FAIL rr_first_grant: v/l/s/d=%b rdy=%b required src0 data ff rdy=01",
                  {out_valid, out_last, out_src, out_data}, in_ready);
      end
      tick();
      drv_data[0] = 8'h3C;
      #1;
      n_vec++;
      if ({out_valid, out_last, out_src, out_data} !== {3'b110, ref_crc(qa)} || in_ready !== 2'b00) begin
         n_err++;
         $display("FAIL rr_first_crc: v/l/s/d=%b rdy=%b required %b rdy=00",
                  {out_valid, out_last, out_src, out_data}, in_ready, {3'b110, ref_crc(qa)});
      end
      tick();
      tick();
      n_vec++;
      if ({out_valid, out_src, out_data} !== {2'b11, 8'h5A} || in_ready !== 2'b10) begin
         n_err++;
         $display("FAIL rr_second_grant: v/s/d=%b rdy=%b required 1101011010 rdy=10",
                  {out_valid, out_src, out_data}, in_ready);
      end
      tick();
      drv_valid[1] = 1'b0;
      #1;
      n_vec++;
      if ({out_valid, out_last, out_src, out_data} !== {3'b111, ref_crc(qb)}) begin
         n_err++;
         $display("FAIL rr_second_crc: v/l/s/d=%b required %b",
                  {out_valid, out_last, out_src, out_data}, {3'b111, ref_crc(qb)});
      end
      tick();
      tick();
      n_vec++;
      if ({out_valid, out_src, out_data} !== {2'b10, 8'h3C} || in_ready !== 2'b01) begin
         n_err++;
         $display("FAIL rr_third_grant: v/s/d=%b rdy=%b required 1000111100 rdy=01",
                  {out_valid, out_src, out_data}, in_ready);
      end
      tick();
      idle_inputs();
      #1;
      n_vec++;
      if ({out_valid, out_last, out_src, out_data} !== {3'b110, ref_crc(qc)}) begin
         n_err++;
         $display("FAIL rr_third_crc: v/l/s/d=%b required %b",
                  {out_valid, out_last, out_src, out_data}, {3'b110, ref_crc(qc)});
      end
      tick();
   endtask

   task automatic test_stall;
      logic [7:0] q[$];
      logic [7:0] one[$];
      logic [7:0] exp_crc;
      q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      one = {8'h00};
      exp_crc = ref_crc(q);
      apply_reset();
      drv_valid[1] = 1'b1; drv_data[1] = q[0]; drv_last[1] = 1'b0;
      tick();
      for (int i = 0; i < q.size(); i++) begin
         drv_data[1] = q[i];
         drv_last[1] = (i == q.size() - 1);
         tick();
      end
      idle_inputs();
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_vec++;
         if ({out_valid, out_last, out_src, out_data} !== {3'b111, exp_crc} || in_ready !== 2'b00) begin
            n_err++;
            $display("FAIL stall_hold[%0d]: v/l/s/d=%b rdy=%b required %b rdy=00", k,
                     {out_valid, out_last, out_src, out_data}, in_ready, {3'b111, exp_crc});
         end
         tick();
      end
`ifdef CRC_STATS_EN
      n_vec++;
      if ({stall_flag, frame_cnt} !== {1'b1, 32'h0}) begin
         n_err++;
         $display("FAIL stall_stats: flag=%b cnt=%h required flag=1 cnt=0", stall_flag, frame_cnt);
      end
`endif
      out_ready = 1'b1;
      tick();
      tick();
      n_vec++;
      if ({busy, out_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL stall_release: busy/out_valid=%b required 00", {busy, out_valid});
      end
`ifdef CRC_STATS_EN
      n_vec++;
      if (frame_cnt !== 32'h0001_0000) begin
         n_err++;
         $display("FAIL stall_count: cnt=%h required 00010000", frame_cnt);
      end
      // Clear on the very cycle the check byte is accepted: clear must win.
      drv_valid[0] = 1'b1; drv_data[0] = 8'h00; drv_last[0] = 1'b1;
      tick();
      tick();
      idle_inputs();
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      n_vec++;
      if ({stall_flag, frame_cnt} !== 33'b0) begin
         n_err++;
         $display("FAIL stats_clr_priority: flag=%b cnt=%h required 0", stall_flag, frame_cnt);
      end
`else
      run_frame(0, one, "post_stall");
`endif
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] q[$];
      q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      apply_reset();
      drv_valid[1] = 1'b1; drv_data[1] = q[0]; drv_last[1] = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         drv_data[1] = q[i];
         tick();
      end
      drv_data[1] = q[4];
      rst = 1'b1;
      #1;
      n_vec++;
      if ({out_valid, out_last, out_src, busy, in_ready} !== 6'b0) begin
         n_err++;
         $display("FAIL midframe_reset: v/l/s/busy/rdy=%b required 000000",
                  {out_valid, out_last, out_src, busy, in_ready});
      end
      tick();
      idle_inputs();
      rst = 1'b0;
      tick();
      run_frame(1, q, "resend");
   endtask

   task automatic test_back_to_back;
      logic [7:0] q[$];
      q = {8'h00};
      apply_reset();
      drv_valid[0] = 1'b1; drv_data[0] = 8'h00; drv_last[0] = 1'b1;
      for (int f = 0; f < 3; f++) begin
         #1;
         n_vec++;
         if ({busy, out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_idle[%0d]: busy/out_valid=%b required 00", f, {busy, out_valid});
         end
         tick();
         n_vec++;
         if ({out_valid, out_last, out_src, out_data} !== 11'b100_0000_0000) begin
            n_err++;
            $display("FAIL b2b_data[%0d]: v/l/s/d=%b required 10000000000", f,
                     {out_valid, out_last, out_src, out_data});
         end
         tick();
         n_vec++;
         if ({out_valid, out_last, out_src, out_data} !== {3'b110, ref_crc(q)}) begin
            n_err++;
            $display("FAIL b2b_crc[%0d]: v/l/s/d=%b required %b", f,
                     {out_valid, out_last, out_src, out_data}, {3'b110, ref_crc(q)});
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic rnd_driver(input int r);
      int  pos;
      int  w;
      logic got;
      pos = 0;
      for (int f = 0; f < NF; f++) begin
         for (int b = 0; b < rnd_len[r][f]; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            drv_valid[r] = 1'b1;
            drv_data[r]  = rnd_bytes[r][pos + b];
            drv_last[r]  = (b == rnd_len[r][f] - 1);
            w = 0;
            forever begin
               @(negedge clk);
               got = in_ready[r];
               tick();
               if (got) break;
               w++;
               if (w > 400 || mon_done) break;
            end
            drv_valid[r] = 1'b0;
            drv_last[r]  = 1'b0;
            if (w > 400 || mon_done) return;
         end
         pos += rnd_len[r][f];
      end
   endtask

   task automatic rnd_ready;
      while (!mon_done) begin
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      out_ready = 1'b1;
   endtask

   task automatic rnd_monitor;
      logic        rr_m;
      logic        src_m;
      int          fi [2];
      int          bi [2];
      int          base [2];
      int          done;
      int          cycles;
      logic        stalled;
      logic [10:0] held;
      logic [7:0]  fq[$];
      logic [8:0]  exp_ld;
      int          s;
      rr_m = 1'b0; src_m = 1'b0; done = 0; cycles = 0; stalled = 1'b0; held = '0;
      for (int r = 0; r < 2; r++) begin fi[r] = 0; bi[r] = 0; base[r] = 0; end
      while (done < 2 * NF && cycles < 6000) begin
         @(negedge clk);
         cycles++;
         if (stalled) begin
            n_vec++;
            if ({out_valid, out_last, out_src, out_data} !== held) begin
               n_err++;
               $display("FAIL rnd_stall_stable: v/l/s/d=%b required %b",
                        {out_valid, out_last, out_src, out_data}, held);
            end
         end
         stalled = out_valid && !out_ready;
         held    = {out_valid, out_last, out_src, out_data};
         if (!busy && in_valid != 2'b00) begin
            src_m = in_valid[rr_m] ? rr_m : ~rr_m;
         end
         n_vec++;
         if (busy ? ((in_ready & ~(src_m ? 2'b10 : 2'b01)) != 2'b00) : (in_ready != 2'b00)) begin
            n_err++;
            $display("FAIL rnd_ready_owner: rdy=%b busy=%b granted=%0d", in_ready, busy, src_m);
         end
         if (out_valid && out_ready) begin
            s = int'(src_m);
            if (fi[s] >= NF) begin
               n_vec++; n_err++;
               $display("FAIL rnd_extra_beat: src=%0d data=%h required no beat", s, out_data);
            end else begin
               if (bi[s] == rnd_len[s][fi[s]]) begin
                  fq = {};
                  for (int k = 0; k < bi[s]; k++) fq.push_back(rnd_bytes[s][base[s] + k]);
                  exp_ld = {1'b1, ref_crc(fq)};
               end else begin
                  exp_ld = {1'b0, rnd_bytes[s][base[s] + bi[s]]};
               end
               n_vec++;
               if ({out_last, out_data} !== exp_ld || out_src !== src_m) begin
                  n_err++;
                  $display("FAIL rnd_beat: src=%0d frame=%0d idx=%0d got l/d=%b s=%b required %b s=%b",
                           s, fi[s], bi[s], {out_last, out_data}, out_src, exp_ld, src_m);
               end
               if (exp_ld[8]) begin
                  base[s] += bi[s];
                  bi[s] = 0;
                  fi[s]++;
                  done++;
                  rr_m = ~src_m;
               end else begin
                  bi[s]++;
               end
            end
         end
      end
      if (done < 2 * NF) begin
         n_vec++; n_err++;
         $display("FAIL rnd_timeout: frames=%0d required %0d", done, 2 * NF);
      end
      mon_done = 1'b1;
   endtask

   task automatic test_random;
      for (int r = 0; r < 2; r++) begin
         rnd_bytes[r] = {};
         rnd_len[r]   = {};
         for (int f = 0; f < NF; f++) begin
            rnd_len[r].push_back(int'($urandom_range(1, 6)));
            for (int b = 0; b < rnd_len[r][f]; b++) rnd_bytes[r].push_back(8'($urandom));
         end
      end
      apply_reset();
      mon_done = 1'b0;
      fork
         rnd_driver(0);
         rnd_driver(1);
         rnd_ready();
         rnd_monitor();
      join
      idle_inputs();
      tick();
`ifdef CRC_STATS_EN
      n_vec++;
      if (frame_cnt !== {16'(NF), 16'(NF)}) begin
         n_err++;
         $display("FAIL rnd_frame_cnt: cnt=%h required %h", frame_cnt, {16'(NF), 16'(NF)});
      end
`endif
   endtask

   initial begin
      idle_inputs();
      mon_done = 1'b0;
      test_reset();
      test_single_byte();
      test_check_vector();
      test_round_robin();
      test_stall();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
